// File: rtl/vrf_wb_arbiter.sv
// Round-robin writeback arbiter for the regfile_vec write port, with a per-register pending-write scoreboard.
// Define VRF_WB_STATS_EN to add the conflict_cnt contention counter output.
module vrf_wb_arbiter #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_VREG  = 16,
  parameter int unsigned VREG_BASE = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valu_valid,
  input  logic [ADDR_W-1:0]   valu_addr,
  input  logic [DATA_W-1:0]   valu_data,
  output logic                valu_ready,
  input  logic                vlsu_valid,
  input  logic [ADDR_W-1:0]   vlsu_addr,
  input  logic [DATA_W-1:0]   vlsu_data,
  output logic                vlsu_ready,
  input  logic                resv_valid,
  input  logic [ADDR_W-1:0]   resv_addr,
  output logic                vwe3,
  output logic [ADDR_W-1:0]   vwa3,
  output logic [DATA_W-1:0]   vwd3,
  output logic [NUM_VREG-1:0] vreg_busy,
  output logic                addr_err
`ifdef VRF_WB_STATS_EN
  ,
  output logic [15:0]         conflict_cnt
`endif
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  grant_e              last_grant;
  logic                xfer;
  logic                sel_in_range;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_VREG-1:0] set_mask;
  logic [NUM_VREG-1:0] clr_mask;

  always_comb begin
    valu_ready = 1'b0;
    vlsu_ready = 1'b0;
    if (rst) begin
      if (valu_valid && vlsu_valid) begin
        valu_ready = (last_grant == GRANT_LSU);
        vlsu_ready = (last_grant == GRANT_ALU);
      end else begin
        valu_ready = valu_valid;
        vlsu_ready = vlsu_valid;
      end
    end
  end

  always_comb begin
    xfer         = valu_ready || vlsu_ready;
    sel_addr     = vlsu_ready ? vlsu_addr : valu_addr;
    sel_data     = vlsu_ready ? vlsu_data : valu_data;
    sel_in_range = (32'(sel_addr) >= VREG_BASE) &&
                   (32'(sel_addr) <  VREG_BASE + NUM_VREG);
  end

  // Decoding against every register index also filters out-of-range addresses.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int unsigned i = 0; i < NUM_VREG; i++) begin
      set_mask[i] = resv_valid && (32'(resv_addr) == VREG_BASE + i);
      clr_mask[i] = vwe3 && (32'(vwa3) == VREG_BASE + i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vwe3       <= 1'b0;
      vwa3       <= '0;
      vwd3       <= '0;
      vreg_busy  <= '0;
      addr_err   <= 1'b0;
      last_grant <= GRANT_LSU;
    end else begin
      vwe3     <= xfer && sel_in_range;
      addr_err <= xfer && !sel_in_range;
      if (xfer && sel_in_range) begin
        vwa3 <= sel_addr;
        vwd3 <= sel_data;
      end
      if (valu_ready) begin
        last_grant <= GRANT_ALU;
      end else if (vlsu_ready) begin
        last_grant <= GRANT_LSU;
      end
      // A reservation landing on the write-pulse cycle marks a new pending writer.
      vreg_busy <= (vreg_busy & ~clr_mask) | set_mask;
    end
  end

`ifdef VRF_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (valu_valid && vlsu_valid && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Scoreboard bench for vrf_wb_arbiter: stimulus queues expected writes, a monitor checks each vwe3 pulse.
module tb_vrf_wb_arbiter;

  localparam logic [127:0] D1 = {16{8'h11}};
  localparam logic [127:0] D2 = {16{8'h22}};
  localparam logic [127:0] D3 = {16{8'h33}};
  localparam logic [127:0] D4 = {16{8'h44}};
  localparam logic [127:0] D5 = {16{8'h55}};
  localparam logic [127:0] D6 = {16{8'h66}};
  localparam logic [127:0] DA = {16{8'hAA}};

  logic         clk = 1'b0;
  logic         rst;
  logic         valu_valid, vlsu_valid, resv_valid;
  logic [4:0]   valu_addr, vlsu_addr, resv_addr;
  logic [127:0] valu_data, vlsu_data;
  logic         valu_ready, vlsu_ready;
  logic         vwe3;
  logic [4:0]   vwa3;
  logic [127:0] vwd3;
  logic [15:0]  vreg_busy;
  logic         addr_err;
`ifdef VRF_WB_STATS_EN
  logic [15:0]  conflict_cnt;
`endif

  typedef struct {
    int unsigned  cyc;
    logic [4:0]   addr;
    logic [127:0] data;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          nvec = 0;
  int          nerr = 0;

  vrf_wb_arbiter #(
    .DATA_W(128),
    .ADDR_W(5),
    .NUM_VREG(16),
    .VREG_BASE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valu_valid(valu_valid),
    .valu_addr(valu_addr),
    .valu_data(valu_data),
    .valu_ready(valu_ready),
    .vlsu_valid(vlsu_valid),
    .vlsu_addr(vlsu_addr),
    .vlsu_data(vlsu_data),
    .vlsu_ready(vlsu_ready),
    .resv_valid(resv_valid),
    .resv_addr(resv_addr),
    .vwe3(vwe3),
    .vwa3(vwa3),
    .vwd3(vwd3),
    .vreg_busy(vreg_busy),
    .addr_err(addr_err)
`ifdef VRF_WB_STATS_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [127:0] d);
    exp_t e;
    e.cyc  = cyc + 1;
    e.addr = a;
    e.data = d;
    expq.push_back(e);
  endtask

  // Monitor: every write pulse must match the queue head and land on its expected cycle.
  always @(negedge clk) begin
    if (vwe3) begin
      if (expq.size() == 0 || expq[0].cyc != cyc) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_write: vwe3=1 vwa3=%0h at cycle %0d, expected vwe3=0", vwa3, cyc);
      end else begin
        mon_e = expq.pop_front();
        chk("write_addr", 128'(vwa3), 128'(mon_e.addr));
        chk("write_data", vwd3, mon_e.data);
      end
    end else if (expq.size() != 0 && expq[0].cyc == cyc) begin
      mon_e = expq.pop_front();
      nvec++;
      nerr++;
      $display("FAIL missed_write: vwe3=0 at cycle %0d, expected write to %0h", cyc, mon_e.addr);
    end
  end

  task automatic idle();
    valu_valid = 1'b0;
    vlsu_valid = 1'b0;
    resv_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    valu_valid = 1'b1; valu_addr = 5'h10; valu_data = DA;
    vlsu_valid = 1'b1; vlsu_addr = 5'h11; vlsu_data = D1;
    resv_valid = 1'b0; resv_addr = 5'h00;

    // Reset held two cycles with requests present: no grants, outputs cleared.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_valu_ready", 128'(valu_ready), 128'(0));
      chk("rst_vlsu_ready", 128'(vlsu_ready), 128'(0));
      chk("rst_busy", 128'(vreg_busy), 128'(16'h0000));
    end
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("idle_vwe3", 128'(vwe3), 128'(0));
    chk("idle_busy", 128'(vreg_busy), 128'(16'h0000));
    chk("idle_addr_err", 128'(addr_err), 128'(0));

    // Contention: first tie after reset goes to the ALU, then alternates.
    valu_valid = 1'b1; valu_addr = 5'h11; valu_data = D1;
    vlsu_valid = 1'b1; vlsu_addr = 5'h12; vlsu_data = D2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("tie_valu_ready", 128'(valu_ready), 128'(k % 2 == 0));
      chk("tie_vlsu_ready", 128'(vlsu_ready), 128'(k % 2 == 1));
      if (k % 2 == 0) push_exp(5'h11, D1);
      else            push_exp(5'h12, D2);
      @(negedge clk);
    end
    idle();

    // Single ALU write.
    @(negedge clk);
    valu_valid = 1'b1; valu_addr = 5'h10; valu_data = DA;
    #1;
    chk("single_valu_ready", 128'(valu_ready), 128'(1));
    chk("single_vlsu_ready", 128'(vlsu_ready), 128'(0));
    push_exp(5'h10, DA);
    @(negedge clk);
    idle();
    @(negedge clk);

    // Scoreboard: reserve, clear by write, then set/clear collision.
    resv_valid = 1'b1; resv_addr = 5'h13;
    @(negedge clk);
    resv_valid = 1'b0;
    chk("resv_busy", 128'(vreg_busy), 128'(16'h0008));
    vlsu_valid = 1'b1; vlsu_addr = 5'h13; vlsu_data = D3;
    #1;
    chk("sb_vlsu_ready", 128'(vlsu_ready), 128'(1));
    push_exp(5'h13, D3);
    @(negedge clk);
    vlsu_valid = 1'b0;
    chk("busy_during_write", 128'(vreg_busy), 128'(16'h0008));
    @(negedge clk);
    chk("busy_after_write", 128'(vreg_busy), 128'(16'h0000));
    valu_valid = 1'b1; valu_addr = 5'h13; valu_data = D4;
    #1;
    push_exp(5'h13, D4);
    @(negedge clk);
    valu_valid = 1'b0;
    resv_valid = 1'b1; resv_addr = 5'h13;
    @(negedge clk);
    resv_valid = 1'b0;
    chk("set_wins_busy", 128'(vreg_busy), 128'(16'h0008));
    @(negedge clk);
    chk("set_wins_hold", 128'(vreg_busy), 128'(16'h0008));

    // Range boundaries for reservations.
    resv_valid = 1'b1; resv_addr = 5'h1F;
    @(negedge clk);
    resv_addr = 5'h0F;
    chk("resv_top_busy", 128'(vreg_busy), 128'(16'h8008));
    @(negedge clk);
    resv_valid = 1'b0;
    chk("resv_oor_busy", 128'(vreg_busy), 128'(16'h8008));

    // Out-of-range writes: accepted, no write, one-cycle addr_err.
    valu_valid = 1'b1; valu_addr = 5'h05; valu_data = D5;
    #1;
    chk("bad_valu_ready", 128'(valu_ready), 128'(1));
    @(negedge clk);
    valu_valid = 1'b0;
    chk("bad_addr_err", 128'(addr_err), 128'(1));
    chk("bad_busy", 128'(vreg_busy), 128'(16'h8008));
    vlsu_valid = 1'b1; vlsu_addr = 5'h0F; vlsu_data = D5;
    #1;
    chk("bad_vlsu_ready", 128'(vlsu_ready), 128'(1));
    @(negedge clk);
    vlsu_valid = 1'b0;
    chk("bad2_addr_err", 128'(addr_err), 128'(1));
    @(negedge clk);
    chk("addr_err_pulse", 128'(addr_err), 128'(0));
    chk("bad2_busy", 128'(vreg_busy), 128'(16'h8008));

    // Top in-range register write clears bit 15.
    vlsu_valid = 1'b1; vlsu_addr = 5'h1F; vlsu_data = D6;
    #1;
    push_exp(5'h1F, D6);
    @(negedge clk);
    vlsu_valid = 1'b0;
    @(negedge clk);
    chk("top_clear_busy", 128'(vreg_busy), 128'(16'h0008));

    // Reset mid-operation, with the ALU as last grant before it.
    resv_valid = 1'b1; resv_addr = 5'h15;
    @(negedge clk);
    resv_valid = 1'b0;
    chk("pre_rst_busy", 128'(vreg_busy), 128'(16'h0028));
    valu_valid = 1'b1; valu_addr = 5'h14; valu_data = D5;
    #1;
    push_exp(5'h14, D5);
    @(negedge clk);
    valu_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_vwe3", 128'(vwe3), 128'(0));
    chk("mid_rst_busy", 128'(vreg_busy), 128'(16'h0000));
    rst = 1'b1;

    // Post-reset contention: ALU must win the first tie again.
    valu_valid = 1'b1; valu_addr = 5'h16; valu_data = D1;
    vlsu_valid = 1'b1; vlsu_addr = 5'h17; vlsu_data = D2;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rtie_valu_ready", 128'(valu_ready), 128'(k % 2 == 0));
      chk("rtie_vlsu_ready", 128'(vlsu_ready), 128'(k % 2 == 1));
      if (k % 2 == 0) push_exp(5'h16, D1);
      else            push_exp(5'h17, D2);
      @(negedge clk);
    end
    idle();
`ifdef VRF_WB_STATS_EN
    chk("conflict_cnt", 128'(conflict_cnt), 128'(16'd3));
`endif

    repeat (3) @(negedge clk);
    chk("pending_writes", 128'(expq.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
